// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one downstream port,
// one transaction in flight at a time, round-robin on conflict, response timeout in RESP.
module mem_arbiter #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [63:0] if_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  input  logic        ls_req_valid,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Timeout fires in the cycle the counter would step onto RESP_TIMEOUT.
  localparam logic [15:0] TIMEOUT_M1 = 16'(RESP_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        ownerLs_q, ownerLs_d;
  logic        lastLs_q, lastLs_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [15:0] wait_q, wait_d;

  logic inIdle, grantIf, grantLs, rspHit, timeout, done;

  assign inIdle  = (state_q == IDLE);
  assign grantLs = ls_req_valid && (!if_req_valid || !lastLs_q);
  assign grantIf = if_req_valid && (!ls_req_valid || lastLs_q);
  assign rspHit  = (state_q == RESP) && mem_rsp_valid;
  assign timeout = (state_q == RESP) && !mem_rsp_valid && (wait_q == TIMEOUT_M1);
  assign done    = rspHit || timeout;

  // Ready is gated by rst_n so a requester never sees a grant while reset is held.
  assign if_req_ready = rst_n && inIdle && grantIf;
  assign ls_req_ready = rst_n && inIdle && grantLs;

  assign if_rsp_valid = done && !ownerLs_q;
  assign ls_rsp_valid = done && ownerLs_q;
  assign rsp_rdata    = rspHit ? mem_rdata : 64'd0;
  assign rsp_err      = timeout;

  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = !inIdle;

  always_comb begin
    state_d   = state_q;
    ownerLs_d = ownerLs_q;
    lastLs_d  = lastLs_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        if (grantLs) begin
          state_d   = REQ;
          ownerLs_d = 1'b1;
          lastLs_d  = 1'b1;
          we_d      = ls_we;
          addr_d    = ls_addr;
          wdata_d   = ls_wdata;
          wmask_d   = ls_we ? ls_wmask : 8'd0;
        end else if (grantIf) begin
          state_d   = REQ;
          ownerLs_d = 1'b0;
          lastLs_d  = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr;
          wdata_d   = 64'd0;
          wmask_d   = 8'd0;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
          wait_d  = 16'd0;
        end
      end
      RESP: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ownerLs_q <= 1'b0;
      lastLs_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      wmask_q   <= 8'd0;
      wait_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      ownerLs_q <= ownerLs_d;
      lastLs_q  <= lastLs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter: each vector is one clock cycle of inputs
// plus the outputs expected mid-cycle, followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;

  typedef struct {
    logic        ifV;
    logic [63:0] ifA;
    logic        lsV;
    logic        lsWe;
    logic [63:0] lsA;
    logic [63:0] lsD;
    logic [7:0]  lsM;
    logic        mRdy;
    logic        mRsp;
    logic [63:0] mData;
  } in_t;

  typedef struct {
    logic        ifRdy;
    logic        lsRdy;
    logic        ifRsp;
    logic        lsRsp;
    logic [63:0] data;
    logic        err;
    logic        memV;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        busy;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [63:0] IFA = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LSA = 64'h0000_0000_0000_1000;
  localparam logic [63:0] LSD = 64'hDEAD_BEEF_CAFE_F00D;
  localparam int NTBL = 15;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr;
  logic        ls_req_valid, ls_we, ls_req_ready, ls_rsp_valid;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy;

  int nVec  = 0;
  int nMiss = 0;
  vec_t tbl [NTBL];

  mem_arbiter #(.RESP_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_addr      (if_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .ls_req_valid (ls_req_valid),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_wmask     (ls_wmask),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic driveInputs(input in_t i);
    if_req_valid  = i.ifV;
    if_addr       = i.ifA;
    ls_req_valid  = i.lsV;
    ls_we         = i.lsWe;
    ls_addr       = i.lsA;
    ls_wdata      = i.lsD;
    ls_wmask      = i.lsM;
    mem_req_ready = i.mRdy;
    mem_rsp_valid = i.mRsp;
    mem_rdata     = i.mData;
  endtask

  // Downstream request fields are only meaningful while mem_req_valid is expected high.
  task automatic checkOutput(input string name, input exp_t e);
    logic ok;
    ok = (if_req_ready === e.ifRdy) && (ls_req_ready === e.lsRdy) &&
         (if_rsp_valid === e.ifRsp) && (ls_rsp_valid === e.lsRsp) &&
         (rsp_rdata === e.data) && (rsp_err === e.err) &&
         (mem_req_valid === e.memV) && (busy === e.busy) &&
         (!e.memV || ((mem_we === e.we) && (mem_addr === e.addr) &&
                      (mem_wdata === e.wdata) && (mem_wmask === e.mask)));
    nVec++;
    if (!ok) begin
      nMiss++;
      $display("[TB] FAIL %s: got rdy=%b%b rsp=%b%b data=%h err=%b memV=%b we=%b addr=%h wd=%h m=%h busy=%b; want rdy=%b%b rsp=%b%b data=%h err=%b memV=%b we=%b addr=%h wd=%h m=%h busy=%b",
               name, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, rsp_rdata, rsp_err,
               mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, busy,
               e.ifRdy, e.lsRdy, e.ifRsp, e.lsRsp, e.data, e.err,
               e.memV, e.we, e.addr, e.wdata, e.mask, e.busy);
    end
  endtask

  task automatic applyStimulus(input string name, input in_t i, input exp_t e);
    @(negedge clk);
    driveInputs(i);
    #2;
    checkOutput(name, e);
  endtask

  initial begin
    in_t  nothing;
    exp_t quiet;
    nothing = '{F, '0, F, F, '0, '0, '0, F, F, '0};
    quiet   = '{F, F, F, F, '0, F, F, F, '0, '0, '0, F};

    tbl[0]  = '{nothing, quiet};
    tbl[1]  = '{'{T, IFA, T, T, LSA, LSD, 8'h0F, F, F, '0}, '{F, T, F, F, '0, F, F, F, '0, '0, '0, F}};
    tbl[2]  = '{'{T, IFA, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, T, LSA, LSD, 8'h0F, T}};
    tbl[3]  = '{'{T, IFA, F, F, '0, '0, '0, F, T, 64'h55}, '{F, F, F, T, 64'h55, F, F, F, '0, '0, '0, T}};
    tbl[4]  = '{'{T, IFA, T, T, LSA, LSD, 8'h0F, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F}};
    tbl[5]  = '{'{F, '0, T, T, LSA, LSD, 8'h0F, T, F, '0}, '{F, F, F, F, '0, F, T, F, IFA, '0, '0, T}};
    tbl[6]  = '{'{F, '0, F, F, '0, '0, '0, F, T, 64'h13}, '{F, F, T, F, 64'h13, F, F, F, '0, '0, '0, T}};
    tbl[7]  = '{'{F, '0, T, F, 64'h2000, '0, 8'hFF, F, F, '0}, '{F, T, F, F, '0, F, F, F, '0, '0, '0, F}};
    tbl[8]  = '{'{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, F, 64'h2000, '0, 8'h00, T}};
    tbl[9]  = '{'{F, '0, F, F, '0, '0, '0, F, T, 64'h1122334455667788}, '{F, F, F, T, 64'h1122334455667788, F, F, F, '0, '0, '0, T}};
    tbl[10] = '{'{F, '0, F, F, '0, '0, '0, F, T, 64'hFFFF}, quiet};
    tbl[11] = '{'{T, 64'h8000_0004, F, F, '0, '0, '0, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F}};
    tbl[12] = '{'{F, '0, F, F, '0, '0, '0, F, T, 64'h77}, '{F, F, F, F, '0, F, T, F, 64'h8000_0004, '0, '0, T}};
    tbl[13] = '{'{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, F, 64'h8000_0004, '0, '0, T}};
    tbl[14] = '{'{F, '0, F, F, '0, '0, '0, F, T, 64'hABCD}, '{F, F, T, F, 64'hABCD, F, F, F, '0, '0, '0, T}};

    // Reset held with every requester and the memory response active: nothing may leak out.
    rst_n = 1'b0;
    driveInputs('{T, IFA, T, T, LSA, LSD, 8'hFF, T, T, 64'h1234});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    checkOutput("in_reset", quiet);
    @(negedge clk);
    driveInputs(nothing);
    rst_n = 1'b1;

    for (int k = 0; k < NTBL; k++) begin
      applyStimulus($sformatf("tbl[%0d]", k), tbl[k].i, tbl[k].e);
    end

    // Downstream stall: request fields must stay put while ready is low.
    applyStimulus("stall_acc", '{F, '0, T, T, 64'h3000, 64'h0123456789ABCDEF, 8'hA5, F, F, '0},
                  '{F, T, F, F, '0, F, F, F, '0, '0, '0, F});
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("stall_wait%0d", k), '{T, IFA, T, F, 64'h9999, 64'h8888, 8'h77, F, F, '0},
                    '{F, F, F, F, '0, F, T, T, 64'h3000, 64'h0123456789ABCDEF, 8'hA5, T});
    end
    applyStimulus("stall_rdy", '{F, '0, F, F, '0, '0, '0, T, F, '0},
                  '{F, F, F, F, '0, F, T, T, 64'h3000, 64'h0123456789ABCDEF, 8'hA5, T});
    applyStimulus("stall_resp1", nothing, '{F, F, F, F, '0, F, F, F, '0, '0, '0, T});
    applyStimulus("stall_done", '{F, '0, F, F, '0, '0, '0, F, T, 64'h99},
                  '{F, F, F, T, 64'h99, F, F, F, '0, '0, '0, T});

    // Timeout after four silent RESP cycles, then a stray response in IDLE.
    applyStimulus("to_acc", '{T, IFA, F, F, '0, '0, '0, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F});
    applyStimulus("to_req", '{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, F, IFA, '0, '0, T});
    for (int k = 1; k <= 3; k++) begin
      applyStimulus($sformatf("to_wait%0d", k), nothing, '{F, F, F, F, '0, F, F, F, '0, '0, '0, T});
    end
    applyStimulus("to_fire", nothing, '{F, F, T, F, '0, T, F, F, '0, '0, '0, T});
    applyStimulus("to_stray", '{F, '0, F, F, '0, '0, '0, F, T, 64'h42}, quiet);

    // Response landing on the timeout cycle completes normally.
    applyStimulus("pr_acc", '{F, '0, T, F, 64'h4000, '0, 8'h3C, F, F, '0}, '{F, T, F, F, '0, F, F, F, '0, '0, '0, F});
    applyStimulus("pr_req", '{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, F, 64'h4000, '0, 8'h00, T});
    for (int k = 1; k <= 3; k++) begin
      applyStimulus($sformatf("pr_wait%0d", k), nothing, '{F, F, F, F, '0, F, F, F, '0, '0, '0, T});
    end
    applyStimulus("pr_hit", '{F, '0, F, F, '0, '0, '0, F, T, 64'h5A}, '{F, F, F, T, 64'h5A, F, F, F, '0, '0, '0, T});

    // Asynchronous reset while waiting in RESP drops the transaction.
    applyStimulus("rs_acc", '{T, IFA, F, F, '0, '0, '0, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F});
    applyStimulus("rs_req", '{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, F, IFA, '0, '0, T});
    applyStimulus("rs_resp", nothing, '{F, F, F, F, '0, F, F, F, '0, '0, '0, T});
    rst_n = 1'b0;
    #1;
    checkOutput("rs_async", quiet);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rs_after", '{T, IFA, T, T, 64'h5000, '0, 8'h01, F, T, 64'h66},
                  '{F, T, F, F, '0, F, F, F, '0, '0, '0, F});
    applyStimulus("rs_req2", '{F, '0, F, F, '0, '0, '0, T, F, '0}, '{F, F, F, F, '0, F, T, T, 64'h5000, '0, 8'h01, T});
    applyStimulus("rs_done", '{F, '0, F, F, '0, '0, '0, F, T, '0}, '{F, F, F, T, '0, F, F, F, '0, '0, '0, T});

    // Asynchronous reset while the downstream request is being presented.
    applyStimulus("rq_acc", '{T, IFA, F, F, '0, '0, '0, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F});
    applyStimulus("rq_req", nothing, '{F, F, F, F, '0, F, T, F, IFA, '0, '0, T});
    rst_n = 1'b0;
    #1;
    checkOutput("rq_async", quiet);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rq_after", '{T, IFA, F, F, '0, '0, '0, F, F, '0}, '{T, F, F, F, '0, F, F, F, '0, '0, '0, F});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
